// File: rtl/data_mem_responder_if.sv
// Load/store request bus between the MEM pipeline stage (master) and the
// wait-state data memory (slave).
interface data_mem_responder_if #(
  parameter int WORD_LEN = 32
);
  logic                mem_r_en;
  logic                mem_w_en;
  logic [WORD_LEN-1:0] addr;
  logic [WORD_LEN-1:0] wr_data;
  logic [WORD_LEN-1:0] rd_data;
  logic                ready;
  logic                freeze;
  logic                err;

  modport master (
    output mem_r_en, mem_w_en, addr, wr_data,
    input  rd_data, ready, freeze, err
  );

  modport slave (
    input  mem_r_en, mem_w_en, addr, wr_data,
    output rd_data, ready, freeze, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MIPS MEM stage: freezes the pipeline for LATENCY
// cycles per access. Define DMEM_PERF_CNT_EN to add rd/wr/stall performance counters.
module data_mem_responder #(
  parameter int WORD_LEN  = 32,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 1024,
  parameter int LATENCY   = 3
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_responder_if.slave bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [15:0]         rd_cnt,
  output logic [15:0]         wr_cnt,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WRD_W = WORD_LEN - 2;

  localparam logic [WORD_LEN-1:0] BASE_BYTE  = WORD_LEN'(BASE_ADDR);
  // BASE_ADDR is word aligned, so the word offset can be taken before subtracting.
  localparam logic [WRD_W-1:0]    BASE_WORD  = WRD_W'(BASE_ADDR / 4);
  localparam logic [WRD_W-1:0]    DEPTH_WORD = WRD_W'(DEPTH);
  localparam logic [3:0]          CNT_INIT   = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_LEN-1:0] wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;
  logic                fault_q, fault_d;
  logic [WORD_LEN-1:0] rd_data_q, rd_data_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;

  logic [WORD_LEN-1:0] mem_q [DEPTH];

  logic                req;
  logic [WRD_W-1:0]    in_word;
  logic                in_fault;
  logic                freeze;
  logic                finish;
  logic                mem_we;
  logic [IDX_W-1:0]    acc_idx;
  logic [WORD_LEN-1:0] acc_wdata;
  logic                acc_wr;
  logic                acc_fault;

  // Request decode straight from the bus; only meaningful while IDLE.
  always_comb begin
    req      = bus.mem_r_en | bus.mem_w_en;
    in_word  = bus.addr[WORD_LEN-1:2] - BASE_WORD;
    in_fault = (bus.addr < BASE_BYTE)
             | (in_word >= DEPTH_WORD)
             | (bus.addr[1:0] != 2'b00)
             | (bus.mem_r_en & bus.mem_w_en);
  end

  // With LATENCY==1 the access completes straight out of IDLE, so the live
  // request is used; otherwise the values latched on acceptance are used.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_idx   = in_word[IDX_W-1:0];
      acc_wdata = bus.wr_data;
      acc_wr    = bus.mem_w_en;
      acc_fault = in_fault;
    end else begin
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_wr    = is_wr_q;
      acc_fault = fault_q;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    fault_d   = fault_q;
    rd_data_d = rd_data_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    freeze    = 1'b0;
    finish    = 1'b0;
    mem_we    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        freeze = req;
        if (req) begin
          idx_d   = in_word[IDX_W-1:0];
          wdata_d = bus.wr_data;
          is_wr_d = bus.mem_w_en;
          fault_d = in_fault;
          if (LATENCY == 1) begin
            finish = 1'b1;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        freeze = 1'b1;
        if (cnt_q == 4'd0) begin
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (finish) begin
      state_d = ST_DONE;
      ready_d = 1'b1;
      err_d   = acc_fault;
      if (acc_wr) begin
        mem_we = ~acc_fault;
      end else begin
        rd_data_d = acc_fault ? '0 : mem_q[acc_idx];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      is_wr_q   <= 1'b0;
      fault_q   <= 1'b0;
      rd_data_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      fault_q   <= fault_d;
      rd_data_q <= rd_data_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  // NOTE: the array is cleared by reset, so it is built from flops rather than
  // a RAM macro; a store in flight when reset hits is simply lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

`ifdef DMEM_PERF_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (finish && !acc_fault && !acc_wr && rd_cnt_q != 16'hFFFF) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end
    if (finish && !acc_fault && acc_wr && wr_cnt_q != 16'hFFFF) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
    if (freeze && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

  // Freeze is forced low during reset even if the pipeline still holds a request.
  assign bus.freeze  = freeze & ~rst;
  assign bus.rd_data = rd_data_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (LATENCY=3, BASE_ADDR=1024, DEPTH=64);
// counter checks are active when DMEM_PERF_CNT_EN is defined.
module tb_data_mem_responder;
  localparam int WL = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  data_mem_responder_if #(.WORD_LEN(WL)) bus ();

`ifdef DMEM_PERF_CNT_EN
  logic [15:0] rd_cnt, wr_cnt, stall_cnt;
`endif

  data_mem_responder #(
    .WORD_LEN (WL),
    .DEPTH    (64),
    .BASE_ADDR(1024),
    .LATENCY  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef DMEM_PERF_CNT_EN
    ,
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1. Holds the request until DONE, checks the freeze window
  // length and DONE outputs, then returns at posedge+1 after leaving DONE.
  task automatic access(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_rd);
    int fz;
    bit done;
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.addr     = a;
    bus.wr_data  = d;
    fz   = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.ready) done = 1'b1;
      else if (bus.freeze) fz++;
    end
    check({tag, " ready_seen"}, 32'(done), 32'd1);
    check({tag, " freeze_cycles"}, 32'(fz), 32'd3);
    check({tag, " freeze_in_done"}, 32'(bus.freeze), 32'd0);
    check({tag, " err"}, 32'(bus.err), 32'(exp_err));
    check({tag, " rd_data"}, bus.rd_data, exp_rd);
    @(posedge clk);
    #1;
  endtask

  // Drops the request and checks the single-cycle ready pulse has ended.
  task automatic go_idle(input string tag);
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    @(negedge clk);
    check({tag, " ready_low"}, 32'(bus.ready), 32'd0);
    check({tag, " freeze_low"}, 32'(bus.freeze), 32'd0);
    check({tag, " err_low"}, 32'(bus.err), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.addr     = '0;
    bus.wr_data  = '0;
    repeat (2) @(negedge clk);
    check("por rd_data", bus.rd_data, 32'd0);
    check("por ready", 32'(bus.ready), 32'd0);
    check("por freeze", 32'(bus.freeze), 32'd0);
    check("por err", 32'(bus.err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill a word and read it so rd_data is non-zero before the reset test.
    access("pre st1024", 1'b0, 1'b1, 32'd1024, 32'd99, 1'b0, 32'd0);
    access("pre ld1024", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 32'd99);
    go_idle("pre");

    // Reset mid-sequence clears outputs and memory.
    rst = 1'b1;
    #1;
    check("rst rd_data", bus.rd_data, 32'd0);
    check("rst ready", 32'(bus.ready), 32'd0);
    check("rst freeze", 32'(bus.freeze), 32'd0);
    check("rst err", 32'(bus.err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    access("rst ld1024", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 32'd0);
    go_idle("rst");

    // Store then load back; the store leaves rd_data alone.
    access("st1032", 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0, 32'd0);
    go_idle("st1032");
    access("ld1032", 1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, 32'hDEADBEEF);
    go_idle("ld1032");

    // Back-to-back loads separated only by DONE.
    access("st1024", 1'b0, 1'b1, 32'd1024, 32'd5, 1'b0, 32'hDEADBEEF);
    access("st1028", 1'b0, 1'b1, 32'd1028, 32'd7, 1'b0, 32'hDEADBEEF);
    access("b2b ld1024", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 32'd5);
    access("b2b ld1028", 1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, 32'd7);
    go_idle("b2b");

    // Last valid word.
    access("st1276", 1'b0, 1'b1, 32'd1276, 32'hA5A5A5A5, 1'b0, 32'd7);
    access("ld1276", 1'b1, 1'b0, 32'd1276, 32'd0, 1'b0, 32'hA5A5A5A5);

    // Faults: misaligned, past the end, below base, read+write together.
    access("ld1025", 1'b1, 1'b0, 32'd1025, 32'd0, 1'b1, 32'd0);
    access("ld1280", 1'b1, 1'b0, 32'd1280, 32'd0, 1'b1, 32'd0);
    access("ld1020", 1'b1, 1'b0, 32'd1020, 32'd0, 1'b1, 32'd0);
    access("rw1024", 1'b1, 1'b1, 32'd1024, 32'hFFFFFFFF, 1'b1, 32'd0);
    access("st1283", 1'b0, 1'b1, 32'd1283, 32'h12345678, 1'b1, 32'd0);
    access("ld1024 after", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 32'd5);
    go_idle("fault");

    // Reset during WAIT with the store still held.
    bus.mem_w_en = 1'b1;
    bus.addr     = 32'd1040;
    bus.wr_data  = 32'h00001234;
    @(negedge clk);
    check("midrst freeze_idle", 32'(bus.freeze), 32'd1);
    @(posedge clk);
    #1;
    check("midrst freeze_wait", 32'(bus.freeze), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst freeze_drop", 32'(bus.freeze), 32'd0);
    bus.mem_w_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    access("midrst ld1040", 1'b1, 1'b0, 32'd1040, 32'd0, 1'b0, 32'd0);
    go_idle("midrst");

    // Fresh reset, then 1 write + 2 reads for the counters.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef DMEM_PERF_CNT_EN
    check("perf rd_cnt reset", 32'(rd_cnt), 32'd0);
    check("perf stall_cnt reset", 32'(stall_cnt), 32'd0);
`endif
    access("perf st1024", 1'b0, 1'b1, 32'd1024, 32'd5, 1'b0, 32'd0);
    go_idle("perf st");
    access("perf ld1024a", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 32'd5);
    go_idle("perf lda");
    access("perf ld1024b", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 32'd5);
    go_idle("perf ldb");
`ifdef DMEM_PERF_CNT_EN
    check("perf rd_cnt", 32'(rd_cnt), 32'd2);
    check("perf wr_cnt", 32'(wr_cnt), 32'd1);
    check("perf stall_cnt", 32'(stall_cnt), 32'd9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
